seq_shift_add_mult: RTL and testbench

Parametrised sequential shift-and-add multiplier. It is the next generation of the fixed 4x4 combinational array multiplier.
- Multiplies two WIDTH-bit operands over WIDTH clock cycles.
- Uses one WIDTH-bit adder instead of a full HA/FA array.
- Has a start/busy/done handshake, so lab top-levels and datapaths can trade area for latency.

---
 rtl/mult_pkg.sv | 12 +
 rtl/full_adder.sv | 13 +
 rtl/ripple_add.sv | 27 ++
 rtl/seq_shift_add_mult.sv | 112 +++++++++++
 tb/tb_seq_shift_add_mult.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared types and defaults for the sequential shift-and-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } mult_state_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used to build ripple-carry adders.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/ripple_add.sv
// Combinational WIDTH-bit ripple-carry adder built from full_adder cells.
module ripple_add #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (carry[i]),
            .s   (sum[i]),
            .cout(carry[i+1])
        );
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-and-add multiplier with start/busy/done handshake, WIDTH+1 cycle latency.
// Define SEQ_MULT_SIGNED_EN to treat x and y as two's complement (sign-magnitude around the unsigned core).
module seq_shift_add_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mult_state_t        state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic [WIDTH-1:0]   x_mag;
    logic [WIDTH-1:0]   y_mag;
    logic [2*WIDTH-1:0] result;
    logic               accept;

`ifdef SEQ_MULT_SIGNED_EN
    logic neg;

    // -x of the most negative value wraps to itself, which read unsigned is exactly its magnitude.
    assign x_mag  = x[WIDTH-1] ? -x : x;
    assign y_mag  = y[WIDTH-1] ? -y : y;
    assign result = neg ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
`else
    assign x_mag  = x;
    assign y_mag  = y;
    assign result = {acc_hi, acc_lo};
`endif

    assign addend = mplier[0] ? mcand : '0;
    assign accept = start && (state == IDLE || state == DONE);

    ripple_add #(.WIDTH(WIDTH)) u_add (
        .a   (acc_hi),
        .b   (addend),
        .sum (add_sum),
        .cout(add_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            p      <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            neg    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: ;
                CALC: begin
                    // {carry, sum, acc_lo} shifted right by one; the low half collects finished product bits.
                    acc_hi <= {add_cout, add_sum[WIDTH-1:1]};
                    acc_lo <= {add_sum[0], acc_lo[WIDTH-1:1]};
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    p     <= result;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // NOTE: non-blocking updates mean this later assignment wins over the case above,
            // so a start seen in DONE both publishes p and launches the next multiply on the same edge.
            if (accept) begin
                state  <= CALC;
                busy   <= 1'b1;
                mcand  <= x_mag;
                mplier <= y_mag;
                acc_hi <= '0;
                acc_lo <= '0;
                cnt    <= '0;
`ifdef SEQ_MULT_SIGNED_EN
                neg    <= x[WIDTH-1] ^ y[WIDTH-1];
`endif
            end
        end
    end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Scoreboard bench for seq_shift_add_mult: WIDTH=4 directed + exhaustive, WIDTH=8 random.
module tb_seq_shift_add_mult;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start4 = 1'b0;
    logic [3:0] x4 = '0, y4 = '0;
    logic       busy4, done4;
    logic [7:0] p4;

    logic        start8 = 1'b0;
    logic [7:0]  x8 = '0, y8 = '0;
    logic        busy8, done8;
    logic [15:0] p8;

    int n_vec  = 0;
    int n_miss = 0;

    logic [63:0] q4[$];
    logic [63:0] q8[$];
    logic [63:0] last_p4 = '0;
    logic [63:0] last_p8 = '0;

    always #5 clk = ~clk;

    seq_shift_add_mult #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .x(x4), .y(y4),
        .busy(busy4), .done(done4), .p(p4)
    );

    seq_shift_add_mult #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .x(x8), .y(y8),
        .busy(busy8), .done(done8), .p(p8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference product: plain integer multiply, truncated to 2*w bits.
    function automatic logic [63:0] model(input int w, input logic [63:0] a, input logic [63:0] b);
        longint sa = longint'(a);
        longint sb = longint'(b);
`ifdef SEQ_MULT_SIGNED_EN
        if (a[w-1]) sa = sa - (longint'(1) << w);
        if (b[w-1]) sb = sb - (longint'(1) << w);
`endif
        return 64'(sa * sb) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    // Monitors: compare on every done pulse, and require p to hold otherwise.
    always @(negedge clk) begin
        if (rst) begin
            q4.delete();
            last_p4 = '0;
        end else if (done4) begin
            if (q4.size() == 0) check("w4_unexpected_done", 64'(done4), 64'd0);
            else check("w4_product", 64'(p4), q4.pop_front());
            last_p4 = 64'(p4);
        end else begin
            check("w4_p_hold", 64'(p4), last_p4);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            q8.delete();
            last_p8 = '0;
        end else if (done8) begin
            if (q8.size() == 0) check("w8_unexpected_done", 64'(done8), 64'd0);
            else check("w8_product", 64'(p8), q8.pop_front());
            last_p8 = 64'(p8);
        end else begin
            check("w8_p_hold", 64'(p8), last_p8);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle4();
        int n = 0;
        while (busy4 && n < 100) begin step(); n++; end
        if (n >= 100) check("w4_idle_timeout", 64'(busy4), 64'd0);
    endtask

    task automatic wait_idle8();
        int n = 0;
        while (busy8 && n < 100) begin step(); n++; end
        if (n >= 100) check("w8_idle_timeout", 64'(busy8), 64'd0);
    endtask

    task automatic issue4(input logic [3:0] a, input logic [3:0] b);
        start4 = 1'b1; x4 = a; y4 = b;
        q4.push_back(model(4, 64'(a), 64'(b)));
        step();
        start4 = 1'b0;
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b);
        start8 = 1'b1; x8 = a; y8 = b;
        q8.push_back(model(8, 64'(a), 64'(b)));
        step();
        start8 = 1'b0;
    endtask

    initial begin
        int busy_cnt, done_at, d1, d2, n;

        // Reset overrides a simultaneous start.
        start4 = 1'b1; x4 = 4'd7; y4 = 4'd7;
        repeat (3) step();
        check("reset_busy", 64'(busy4), 64'd0);
        check("reset_done", 64'(done4), 64'd0);
        check("reset_p", 64'(p4), 64'd0);
        check("reset_p8", 64'(p8), 64'd0);
        start4 = 1'b0;
        rst = 1'b0;
        repeat (2) step();

        // 15*15: latency and busy width.
        issue4(4'd15, 4'd15);
        busy_cnt = 0; done_at = 0;
        for (int k = 1; k <= 12; k++) begin
            if (busy4) busy_cnt++;
            step();
            if (done4 && done_at == 0) done_at = k;
        end
        check("w4_done_latency", 64'(done_at), 64'd5);
        check("w4_busy_cycles", 64'(busy_cnt), 64'd4);

        // Back-to-back: start held through DONE.
        wait_idle4(); repeat (3) step();
        start4 = 1'b1; x4 = 4'd3; y4 = 4'd5;
        q4.push_back(model(4, 64'd3, 64'd5));
        step();
        x4 = 4'd0; y4 = 4'd9;
        q4.push_back(model(4, 64'd0, 64'd9));
        d1 = 0; d2 = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (done4 && d1 == 0) begin d1 = k; start4 = 1'b0; end
            else if (done4 && d2 == 0) d2 = k;
        end
        start4 = 1'b0;
        check("b2b_first_done", 64'(d1), 64'd5);
        check("b2b_done_gap", 64'(d2 - d1), 64'd5);

        // Start pulse and operand changes mid-CALC are ignored.
        wait_idle4(); repeat (3) step();
        issue4(4'd6, 4'd7);
        step();
        start4 = 1'b1; x4 = 4'd15; y4 = 4'd15;
        step();
        start4 = 1'b0; x4 = 4'($urandom); y4 = 4'($urandom);
        wait_idle4(); repeat (4) step();

        // Reset two cycles into CALC aborts without a done pulse.
        issue4(4'd9, 4'd11);
        step();
        step();
        rst = 1'b1;
        step();
        check("abort_busy", 64'(busy4), 64'd0);
        check("abort_done", 64'(done4), 64'd0);
        check("abort_p", 64'(p4), 64'd0);
        rst = 1'b0;
        repeat (10) step();

        // Signed corner operands (plain unsigned products when the feature is off).
        issue4(4'h8, 4'h8); wait_idle4();
        issue4(4'hD, 4'h5); wait_idle4();
        issue4(4'h7, 4'hF); wait_idle4();

        // Exhaustive WIDTH=4 sweep, back-to-back when DONE allows.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                wait_idle4();
                issue4(4'(a), 4'(b));
            end
        end

        // Random WIDTH=8 sweep plus corners.
        issue8(8'hFF, 8'hFF); wait_idle8();
        issue8(8'h80, 8'h80); wait_idle8();
        issue8(8'h80, 8'hFF); wait_idle8();
        for (int i = 0; i < 300; i++) begin
            wait_idle8();
            issue8(8'($urandom), 8'($urandom));
        end

        // Drain outstanding results.
        n = 0;
        while ((q4.size() != 0 || q8.size() != 0 || busy4 || busy8) && n < 200) begin
            step(); n++;
        end
        if (n >= 200) check("drain_timeout", 64'(q4.size() + q8.size()), 64'd0);
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
